// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX multi-cycle sequencer.
// pc_cmd is declared [0:1] so the literal 2'b10 puts the "redirect" bit at index 0.
package dlx_pkg;

    typedef enum logic [2:0] {
        S_IF,
        S_IWAIT,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef logic [0:1] pc_cmd_t;

    localparam pc_cmd_t PC_INC = 2'b00;
    localparam pc_cmd_t PC_REL = 2'b10;
    localparam pc_cmd_t PC_ABS = 2'b11;

    localparam logic [7:0] DEF_TIMEOUT = 8'd255;

    // A jump always outranks a branch.
    function automatic pc_cmd_t pc_next(input logic is_jump, input logic jump_abs,
                                        input logic is_branch, input logic br_taken);
        if (is_jump) begin
            return jump_abs ? PC_ABS : PC_REL;
        end
        if (is_branch && br_taken) begin
            return PC_REL;
        end
        return PC_INC;
    endfunction

endpackage

// File: rtl/dlx_seq_if.sv
// Bundle between the DLX sequencer (master) and its decoder/memory environment (slave).
interface dlx_seq_if;

    logic             i_ack;
    logic             d_ack;
    logic             is_load;
    logic             is_store;
    logic             is_jump;
    logic             jump_abs;
    logic             is_branch;
    logic             br_taken;
    logic             halt;

    logic             IF;
    logic             ID;
    logic             EX;
    logic             MEM;
    logic             WB;
    dlx_pkg::pc_cmd_t pc_cmd;
    logic             i_req;
    logic             d_req;
    logic             d_we;
    logic             wb_en;
    logic             halted;
    logic             bus_err;
    logic [31:0]      retired;

    modport master (
        input  i_ack, d_ack, is_load, is_store, is_jump, jump_abs, is_branch, br_taken, halt,
        output IF, ID, EX, MEM, WB, pc_cmd, i_req, d_req, d_we, wb_en, halted, bus_err, retired
    );

    modport slave (
        output i_ack, d_ack, is_load, is_store, is_jump, jump_abs, is_branch, br_taken, halt,
        input  IF, ID, EX, MEM, WB, pc_cmd, i_req, d_req, d_we, wb_en, halted, bus_err, retired
    );

endinterface

// File: rtl/bus_wdog.sv
// Bus-wait watchdog: counts waiting cycles and flags the cycle in which the count reaches limit.
module bus_wdog (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (enable && (cnt_q != 8'hff)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires in the waiting cycle whose increment would make the count equal limit.
    assign expired = enable && (({1'b0, cnt_q} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/dlx_seq.sv
// DLX multi-cycle control sequencer: fetch/decode/execute/memory/writeback phase strobes,
// PC command, memory requests with bus-wait timeout, and a retired-instruction counter.
module dlx_seq
    import dlx_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = DEF_TIMEOUT
) (
    input logic       clk,
    input logic       reset_n,
    dlx_seq_if.master bus
);

    state_e      state_q;
    state_e      state_d;
    pc_cmd_t     pc_cmd_q;
    logic        d_we_q;
    logic        wb_ok_q;
    logic        bus_err_q;
    logic [31:0] retired_q;

    logic        waiting;
    logic        entering_wait;
    logic        expired;
    logic        timeout_hit;

    assign waiting       = (state_q == S_IWAIT) || (state_q == S_MEM);
    assign entering_wait = ((state_d == S_IWAIT) || (state_d == S_MEM)) && !waiting;
    assign timeout_hit   = expired && (((state_q == S_IWAIT) && !bus.i_ack) ||
                                       ((state_q == S_MEM) && !bus.d_ack));

    bus_wdog u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (entering_wait),
        .enable  (waiting),
        .limit   (TIMEOUT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IF:    state_d = S_IWAIT;
            S_IWAIT: begin
                // An ack in the expiring cycle still wins.
                if (bus.i_ack) begin
                    state_d = S_ID;
                end else if (expired) begin
                    state_d = S_HALT;
                end
            end
            S_ID:    state_d = bus.halt ? S_HALT : S_EX;
            S_EX:    state_d = (bus.is_load || bus.is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.d_ack) begin
                    state_d = S_WB;
                end else if (expired) begin
                    state_d = S_HALT;
                end
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Instruction attributes are captured in EX; the decoder flags are not valid afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_cmd_q  <= PC_INC;
            d_we_q    <= 1'b0;
            wb_ok_q   <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            if (state_q == S_EX) begin
                pc_cmd_q <= pc_next(bus.is_jump, bus.jump_abs, bus.is_branch, bus.br_taken);
                d_we_q   <= bus.is_store;
                wb_ok_q  <= !(bus.is_store || bus.is_branch || bus.is_jump);
            end else if (state_q == S_IF) begin
                pc_cmd_q <= PC_INC;
            end
            if (state_q == S_WB) begin
                retired_q <= retired_q + 32'd1;
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Strobes are masked while reset is held so the first IF appears only once it is released.
    always_comb begin
        bus.IF      = 1'b0;
        bus.ID      = 1'b0;
        bus.EX      = 1'b0;
        bus.MEM     = 1'b0;
        bus.WB      = 1'b0;
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.wb_en   = 1'b0;
        bus.halted  = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                S_IF:    bus.IF = 1'b1;
                S_IWAIT: bus.i_req = 1'b1;
                S_ID:    bus.ID = 1'b1;
                S_EX:    bus.EX = 1'b1;
                S_MEM: begin
                    bus.MEM   = 1'b1;
                    bus.d_req = 1'b1;
                    bus.d_we  = d_we_q;
                end
                S_WB: begin
                    bus.WB    = 1'b1;
                    bus.wb_en = wb_ok_q;
                end
                S_HALT:  bus.halted = 1'b1;
                default: bus.halted = 1'b1;
            endcase
        end
        bus.pc_cmd  = pc_cmd_q;
        bus.bus_err = bus_err_q;
        bus.retired = retired_q;
    end

endmodule

// File: doc/dlx_seq.md
DLX_SEQ -- requirements
Module: dlx_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, bus-wait cycles before bus error.
REQ-002 SHALL have clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have i_ack  in  1  instruction memory done.
REQ-005 SHALL have d_ack  in  1  data memory done.
REQ-006 SHALL have is_load, is_store, is_jump, jump_abs, is_branch, br_taken, halt  in  1 each  decoder flags, valid in ID and EX.
REQ-007 SHALL have IF, ID, EX, MEM, WB  out  1 each  phase strobes, at most one high.
REQ-008 SHALL have pc_cmd  out  2 (bits [0:1])  PC command: 00 = +4, 10 = relative, 11 = absolute.
REQ-009 SHALL have i_req, d_req, d_we, wb_en  out  1 each  memory requests, store select, register write enable.
REQ-010 SHALL have halted, bus_err  out  1 each  sticky status.
REQ-011 SHALL have retired  out  32  retired-instruction count.

Function
REQ-012 SHALL implement states S_IF, S_IWAIT, S_ID, S_EX, S_MEM, S_WB, S_HALT.
REQ-013 S_IF: IF=1 for exactly one cycle, then S_IWAIT; one IF pulse per instruction, never two.
REQ-014 S_IWAIT: i_req=1; on i_ack go S_ID; i_req drops on the edge that sees i_ack.
REQ-015 S_ID: ID=1 for one cycle; halt=1 -> S_HALT (halt beats all other flags); else S_EX.
REQ-016 S_EX: EX=1 for one cycle; is_load|is_store -> S_MEM, else S_WB.
REQ-017 S_EX SHALL register next pc_cmd: is_jump&jump_abs -> 11; is_jump&!jump_abs, or is_branch&br_taken -> 10; else 00; is_jump beats is_branch.
REQ-018 pc_cmd SHALL hold its registered value through the next S_IF cycle and return to 00 on the edge leaving S_IF.
REQ-019 S_MEM: MEM=1, d_req=1, d_we=is_store (sampled in EX, held); on d_ack go S_WB.
REQ-020 S_WB: WB=1 for one cycle; wb_en=1 unless instruction was store, branch or non-linking jump; then S_IF.
REQ-021 retired SHALL increment by 1 on each S_WB exit; wraps FFFF_FFFF -> 0.
REQ-022 Wait counter (8-bit) SHALL clear on entry to S_IWAIT/S_MEM and increment each waiting cycle; reaching TIMEOUT without ack -> bus_err=1, go S_HALT.
REQ-023 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (normal progress, no bus_err).
REQ-024 i_ack outside S_IWAIT and d_ack outside S_MEM SHALL be ignored.
REQ-025 S_HALT: halted=1, all strobes and requests 0; exit only via reset.
REQ-026 Minimum latency: ALU instruction 5 cycles with zero-wait i_ack (IF, IWAIT, ID, EX, WB); load/store 6 cycles.

Reset
REQ-027 reset_n=0 at an edge SHALL force S_IF, pc_cmd=00, all strobes/requests 0, wait counter 0, retired=0, halted=0, bus_err=0.
REQ-028 Reset mid-S_IWAIT or mid-S_MEM SHALL abandon the transfer; i_req/d_req low from the next edge.
REQ-029 First IF pulse SHALL occur on the first cycle after reset_n deasserts.

Structure
REQ-030 dlx_pkg SHALL hold the state enum, PC_INC/PC_REL/PC_ABS pc_cmd constants, default TIMEOUT.
REQ-031 Wait counter SHALL be sub-module bus_wdog (clear, enable, limit in; expired out); the rest is flat FSM plus registered outputs.

Verification
REQ-032 ALU instruction, i_ack one cycle after i_req -> strobes IF,ID,EX,WB in order, wb_en=1, retired 0->1, pc_cmd=00 at next IF.
REQ-033 Taken branch at EX -> pc_cmd=10 during next IF only; absolute jump -> 11; jump+branch both set -> 11/10 per jump_abs.
REQ-034 Load with d_ack after 3 wait cycles -> d_req high 4 cycles, d_we=0; store -> d_we=1, wb_en=0.
REQ-035 i_ack withheld, TIMEOUT=4 -> bus_err=1, halted=1 after 4 wait cycles; i_ack on the 4th cycle -> no bus_err.
REQ-036 halt in ID -> S_HALT, no EX pulse; then reset_n low one edge -> IF pulse next cycle, retired=0.
